// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the core's memory stage
// (master) and the memory-side responder (slave).
interface data_mem_responder_if;
    logic        request;
    logic        we_re;
    logic [3:0]  mask;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        valid;
    logic        error;

    modport master (
        output request, we_re, mask, address, store_data,
        input  load_data, valid, error
    );

    modport slave (
        input  request, we_re, mask, address, store_data,
        output load_data, valid, error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder: captures one request in IDLE, waits LATENCY cycles,
// then performs a byte-masked write or a full-word read and pulses valid.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Overlay the enabled byte lanes of new_word onto old_word.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lanes
    );
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [3:0]  r_mask;
    logic [29:0] r_word_idx;
    logic [31:0] r_store_data;
    logic [31:0] r_load_data;
    logic        r_valid;
    logic        r_error;
    logic [31:0] r_mem [0:DEPTH_WORDS-1];

    logic [1:0]       w_next_state;
    logic [3:0]       w_next_cnt;
    logic             w_capture;
    logic             w_in_range;
    logic [IDX_W-1:0] w_mem_idx;
    logic [31:0]      w_rd_word;
    logic             w_mem_we;

    // The full 30-bit index is compared so high addresses never alias low words.
    assign w_in_range = (r_word_idx < DEPTH_LIMIT);
    assign w_mem_idx  = r_word_idx[IDX_W-1:0];
    assign w_rd_word  = r_mem[w_mem_idx];
    assign w_mem_we   = (r_state == ST_RESP) && r_we && w_in_range;

    // Next-state and wait-counter logic.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.request) begin
                    w_capture = 1'b1;
                    if (LATENCY == 0) begin
                        w_next_state = ST_RESP;
                        w_next_cnt   = 4'd0;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_next_cnt   = 4'(LATENCY);
                    end
                end else begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = 4'd0;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = ST_RESP;
                    w_next_cnt   = 4'd0;
                end else begin
                    w_next_state = ST_WAIT;
                    w_next_cnt   = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // State and counter registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Holding registers: inputs are sampled only when a request is accepted in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we         <= 1'b0;
            r_mask       <= 4'd0;
            r_word_idx   <= 30'd0;
            r_store_data <= 32'd0;
        end else if (w_capture) begin
            r_we         <= bus.we_re;
            r_mask       <= bus.mask;
            r_word_idx   <= bus.address[31:2];
            r_store_data <= bus.store_data;
        end else begin
            r_we         <= r_we;
            r_mask       <= r_mask;
            r_word_idx   <= r_word_idx;
            r_store_data <= r_store_data;
        end
    end

    // Registered response: one-cycle valid, error on out-of-range, read data held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_load_data <= 32'd0;
        end else if (r_state == ST_RESP) begin
            r_valid <= 1'b1;
            if (!w_in_range) begin
                r_error     <= 1'b1;
                r_load_data <= 32'd0;
            end else if (r_we) begin
                r_error     <= 1'b0;
                r_load_data <= r_load_data;
            end else begin
                r_error     <= 1'b0;
                r_load_data <= w_rd_word;
            end
        end else begin
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_load_data <= r_load_data;
        end
    end

    // Storage array: no reset so contents survive rst; writes commit on the response edge.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= merge_bytes(w_rd_word, r_store_data, r_mask);
        end else begin
            r_mem[w_mem_idx] <= r_mem[w_mem_idx];
        end
    end

    assign bus.load_data = r_load_data;
    assign bus.valid     = r_valid;
    assign bus.error     = r_error;

endmodule
